// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU round-robin scheduler
//
// Purpose: ALU bus widths, the ALU opcode set and the scheduler state encoding.
// Ports: none (package).

package alu_pkg;

  localparam int OPC_W  = 3;
  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    OPC_ADD = 3'd0,
    OPC_SUB = 3'd1,
    OPC_AND = 3'd2,
    OPC_OR  = 3'd3,
    OPC_XOR = 3'd4,
    OPC_NOT = 3'd5,
    OPC_SHL = 3'd6,
    OPC_SHR = 3'd7
  } alu_opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: finds the first asserted request at or after ptr, wrapping N-1 -> 0.
// Ports:
//   req     in  [N-1:0]   request vector
//   ptr     in  [IW-1:0]  highest-priority index for this search
//   gnt     out [N-1:0]   one-hot grant (zero when no request)
//   gnt_idx out [IW-1:0]  index of the granted request (0 when none)
//   any     out           at least one request is asserted

module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      // Once a winner is found, later (lower-priority) slots are ignored.
      if (!any && req[IW'(j)]) begin
        any          = 1'b1;
        gnt[IW'(j)]  = 1'b1;
        gnt_idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// rtl/alu_rr_sched.sv - round-robin scheduler sharing one ALU among N_REQ requesters
//
// Purpose: accepts one operation at a time, issues it to the ALU, waits ALU_LAT
// cycles, and returns the result to the originating requester as a one-cycle strobe.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_valid/req_ready  [N_REQ]     per-requester handshake (ready one-hot or zero)
//   req_opcode/op1/op2   packed      requester i at slice [i*W +: W]
//   alu_opcode/op1/op2   out         ALU operand bus, zero outside ISSUE/WAIT
//   alu_start            out         single-cycle issue strobe
//   alu_result           in          ALU result
//   rsp_valid [N_REQ]    out         one-hot response strobe
//   rsp_data             out         captured result, valid with rsp_valid
//   busy                 out         high in any state other than IDLE

module alu_rr_sched #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int OPC_W   = alu_pkg::OPC_W,
  parameter int ALU_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*OPC_W-1:0]    req_opcode,
  input  logic [N_REQ*DATA_W-1:0]   req_op1,
  input  logic [N_REQ*DATA_W-1:0]   req_op2,
  output logic [OPC_W-1:0]          alu_opcode,
  output logic [DATA_W-1:0]         alu_op1,
  output logic [DATA_W-1:0]         alu_op2,
  output logic                      alu_start,
  input  logic [DATA_W-1:0]         alu_result,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  import alu_pkg::*;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_t        state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [2:0]          wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic [N_REQ-1:0]    gnt;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_any;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      opc_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      wait_cnt_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      opc_q      <= opc_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      wait_cnt_q <= wait_cnt_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    opc_d      = opc_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    wait_cnt_d = wait_cnt_q;
    rsp_data_d = rsp_data_q;
    req_ready  = '0;
    alu_start  = 1'b0;
    alu_opcode = '0;
    alu_op1    = '0;
    alu_op2    = '0;
    rsp_valid  = '0;
    rsp_data   = '0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          // Ready is masked while reset is held so no handshake appears to complete.
          req_ready  = rst ? '0 : gnt;
          idx_d      = gnt_idx;
          opc_d      = req_opcode[gnt_idx*OPC_W +: OPC_W];
          op1_d      = req_op1[gnt_idx*DATA_W +: DATA_W];
          op2_d      = req_op2[gnt_idx*DATA_W +: DATA_W];
          rr_ptr_d   = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        alu_start  = 1'b1;
        alu_opcode = opc_q;
        alu_op1    = op1_q;
        alu_op2    = op2_q;
        wait_cnt_d = 3'(ALU_LAT - 1);
        state_d    = WAIT;
      end
      WAIT: begin
        alu_opcode = opc_q;
        alu_op1    = op1_q;
        alu_op2    = op2_q;
        if (wait_cnt_q == 3'd0) begin
          rsp_data_d = alu_result;
          state_d    = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      RESP: begin
        rsp_valid[idx_q] = 1'b1;
        rsp_data         = rsp_data_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
